// File: rtl/piso_ser.sv
// Parallel-in/serial-out serializer with a load/ready handshake and gapless frame chaining.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_ser #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        sout       = 1'b0;
        sout_valid = 1'b0;
`ifdef PISO_PARITY_EN
        done  = (state_q == PARITY);
        ready = (state_q == IDLE) || (state_q == PARITY);
`else
        done  = last_bit;
        ready = (state_q == IDLE) || last_bit;
`endif
        accept = load && ready;

        case (state_q)
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                sout_valid = 1'b1;
                sout       = par_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                        : {shreg_q[WIDTH-2:0], 1'b0};
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // An accept on the final frame cycle overrides the return to IDLE, chaining frames without a gap.
        if (accept) begin
            state_d = SHIFT;
            shreg_d = din;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            par_d   = ^din;
`endif
        end
    end

endmodule

// File: doc/piso_ser.md
Name: piso_ser

Overview:
Parallel-in/serial-out serializer that sits directly upstream of the 4-bit serial-in/parallel-out register and drives its `sin` input.
- Accepts a WIDTH-bit word through a load/ready handshake.
- Emits the word one bit per clock on `sout`, qualified by `sout_valid`.
- Pulses `done` on the final bit of each frame.
- Supports gapless back-to-back frames, so the downstream SIPO sees a continuous bit stream.

Parameters:
- WIDTH, 4: word width in bits; legal range 2..32.
- LSB_FIRST, 0: 0 = MSB shifted out first; 1 = LSB shifted out first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- load  input  1  word-valid request; a word is accepted at a rising edge when load=1 and ready=1.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data, connects to the downstream `sin`.
- sout_valid  output  1  `sout` carries a frame bit this cycle.
- done  output  1  one-cycle pulse, high during the last bit of a frame.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high. All storage is updated only on the rising edge of `clk`.
- Reset (rst=1 at an edge): state=IDLE, shift register=0, bit counter=0. Resulting outputs: ready=1, sout=0, sout_valid=0, done=0.
- Reset priority: rst beats load at the same edge.
- Reset mid-frame: the frame is aborted, no done is produced, and the block is IDLE in the next cycle.
- States:
  - IDLE: ready=1, sout=0, sout_valid=0, done=0.
  - SHIFT: sout_valid=1, sout = shreg[WIDTH-1] (or shreg[0] when LSB_FIRST=1).
  - PARITY: exists only with the optional feature.
- Accept: load & ready at edge N:
  - shreg <= din, cnt <= 0, state <= SHIFT.
  - The first bit appears on sout in cycle N+1.
  - Bit k appears in cycle N+1+k.
  - Latency from accept to first bit = 1 cycle; frame length = WIDTH cycles.
- Each SHIFT edge (not last bit): shreg shifts by one toward the output end, zero-filled; cnt <= cnt+1.
- Last bit (cnt == WIDTH-1):
  - done=1 and ready=1, both combinational from state/cnt.
  - If load=1 at that edge: the new word is captured, the block stays in SHIFT with cnt=0, and the next frame starts with no idle gap.
  - Otherwise: state <= IDLE.
- ready = (state==IDLE) | last-frame-cycle. It is 0 during all other SHIFT cycles.
- load while ready=0: ignored, with no effect on the data in flight. din is sampled only at the accept edge and may change freely afterwards.
- cnt width = clog2(WIDTH). cnt never exceeds WIDTH-1; no wrap beyond the frame.
- The downstream SIPO sampling on the same clk edges holds the complete word WIDTH edges after the first bit is presented.

Optional Feature:
- Macro: PISO_PARITY_EN
- Defined:
  - At accept, par <= ^din (even parity).
  - After the last data bit the block enters PARITY for one cycle: sout=par, sout_valid=1.
  - done and ready move from the last data bit to the PARITY cycle. Frame length = WIDTH+1.
  - A load accepted during PARITY chains gaplessly into SHIFT.
- Undefined: no PARITY state and no par register. Frame length = WIDTH, as described above.

Test Plan (WIDTH=4 unless noted):
1. Reset: hold rst=1 for 2 edges with load=1 -> ready=1, sout=0, sout_valid=0, done=0, and no frame starts.
2. Single frame: load=1 with din=4'b1011 for one edge -> following 4 cycles give sout=1,0,1,1; sout_valid=1 for exactly 4 cycles; done=1 only in the 4th; ready=0 in cycles 1-3.
3. Back-to-back: load 1011, then load 0110 during the done cycle -> 8 consecutive valid bits 1,0,1,1,0,1,1,0; done pulses in cycles 4 and 8; no idle gap.
4. Busy load ignored: load 1011, then pulse load with din=1111 in cycle 2 -> output stays 1,0,1,1, and no second frame follows.
5. Reset mid-frame: assert rst after 2 bits of 1011 -> next cycle sout_valid=0, sout=0, ready=1; done never asserts. LSB_FIRST=1 with 1011 -> 1,1,0,1.
6. PISO_PARITY_EN defined: load 1011 -> sout=1,0,1,1,1 (parity bit 1); done only in the 5th cycle. Load 0110 -> 0,1,1,0,0.
